// File: rtl/multimode_wave_generator.sv
// ---------------------------------------------------------------------------
// multimode_wave_generator: tick-divided triangle / saw / square sample source
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multimode_wave_generator #(
  parameter int WIDTH       = 16,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_INC = 256,
  parameter int DEFAULT_DIV = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    cfg_load,
  input  logic [1:0]              cfg_mode,
  input  logic [DIV_WIDTH-1:0]    cfg_div,
  input  logic [WIDTH-1:0]        cfg_inc,
  output logic signed [WIDTH-1:0] wave_out,
  output logic                    valid,
  output logic                    period_start,
  output logic                    cfg_pending
);

  typedef enum logic [1:0] {
    MODE_TRI    = 2'b00,
    MODE_SAWUP  = 2'b01,
    MODE_SQUARE = 2'b10,
    MODE_SAWDN  = 2'b11
  } mode_e;

  localparam logic signed [WIDTH:0]   C_MAX_X = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH:0]   C_MIN_X = {2'b11, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] C_MAX   = C_MAX_X[WIDTH-1:0];
  localparam logic signed [WIDTH-1:0] C_MIN   = C_MIN_X[WIDTH-1:0];

  mode_e                    mode_q, mode_d, pmode_q, pmode_d;
  logic [DIV_WIDTH-1:0]     div_q, div_d, pdiv_q, pdiv_d, cnt_q, cnt_d;
  logic [WIDTH-1:0]         inc_q, inc_d, pinc_q, pinc_d;
  logic signed [WIDTH-1:0]  acc_q, acc_d, wave_q, wave_d;
  logic                     dir_q, dir_d, pend_q, pend_d;
  logic                     valid_q, valid_d, pstart_q, pstart_d;

  logic [WIDTH-1:0]         inc_eff;
  logic signed [WIDTH:0]    inc_x, acc_x, up_lim, dn_lim;
  logic                     over_up, under_dn;
  logic signed [WIDTH-1:0]  acc_inc, acc_dec, step_acc, step_wave, start_val;
  logic                     step_dir, step_wrap, tick, apply;

  // Limits are evaluated one bit wider so MAX-inc / MIN+inc cannot wrap.
  assign inc_eff  = (inc_q == '0) ? WIDTH'(1) : inc_q;
  assign inc_x    = $signed({1'b0, inc_eff});
  assign acc_x    = {acc_q[WIDTH-1], acc_q};
  assign up_lim   = C_MAX_X - inc_x;
  assign dn_lim   = C_MIN_X + inc_x;
  assign over_up  = acc_x > up_lim;
  assign under_dn = acc_x < dn_lim;
  assign acc_inc  = acc_q + inc_eff;
  assign acc_dec  = acc_q - inc_eff;

  always_comb begin
    step_acc  = acc_q;
    step_dir  = dir_q;
    step_wrap = 1'b0;
    unique case (mode_q)
      MODE_TRI: begin
        if (!dir_q) begin
          if (over_up) begin
            step_acc = C_MAX;
            step_dir = 1'b1;
          end else begin
            step_acc = acc_inc;
          end
        end else if (under_dn) begin
          step_acc  = C_MIN;
          step_dir  = 1'b0;
          step_wrap = 1'b1;
        end else begin
          step_acc = acc_dec;
        end
      end
      MODE_SAWUP, MODE_SQUARE: begin
        if (over_up) begin
          step_acc  = C_MIN;
          step_wrap = 1'b1;
        end else begin
          step_acc = acc_inc;
        end
      end
      MODE_SAWDN: begin
        if (under_dn) begin
          step_acc  = C_MAX;
          step_wrap = 1'b1;
        end else begin
          step_acc = acc_dec;
        end
      end
      default: ;
    endcase
    step_wave = (mode_q == MODE_SQUARE) ? (step_acc[WIDTH-1] ? C_MIN : C_MAX) : step_acc;
  end

  // A pending config only lands at a period boundary, or at once while frozen.
  assign start_val = (pmode_q == MODE_SAWDN) ? C_MAX : C_MIN;
  assign tick      = enable && (cnt_q == div_q);
  assign apply     = pend_q && (enable ? (tick && step_wrap) : 1'b1);

  always_comb begin
    mode_d   = mode_q;
    div_d    = div_q;
    inc_d    = inc_q;
    pmode_d  = pmode_q;
    pdiv_d   = pdiv_q;
    pinc_d   = pinc_q;
    pend_d   = pend_q;
    acc_d    = acc_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    wave_d   = wave_q;
    valid_d  = 1'b0;
    pstart_d = 1'b0;
    if (enable && !tick) begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
    if (apply) begin
      mode_d   = pmode_q;
      div_d    = pdiv_q;
      inc_d    = pinc_q;
      acc_d    = start_val;
      wave_d   = start_val;
      dir_d    = 1'b0;
      cnt_d    = '0;
      valid_d  = enable;
      pstart_d = enable;
      pend_d   = 1'b0;
    end else if (tick) begin
      acc_d    = step_acc;
      dir_d    = step_dir;
      wave_d   = step_wave;
      cnt_d    = '0;
      valid_d  = 1'b1;
      pstart_d = step_wrap;
    end
    if (cfg_load) begin
      pmode_d = mode_e'(cfg_mode);
      pdiv_d  = cfg_div;
      pinc_d  = cfg_inc;
      pend_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= MODE_TRI;
      div_q    <= DIV_WIDTH'(DEFAULT_DIV);
      inc_q    <= WIDTH'(DEFAULT_INC);
      pmode_q  <= MODE_TRI;
      pdiv_q   <= '0;
      pinc_q   <= '0;
      pend_q   <= 1'b0;
      acc_q    <= C_MIN;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      wave_q   <= C_MIN;
      valid_q  <= 1'b0;
      pstart_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      div_q    <= div_d;
      inc_q    <= inc_d;
      pmode_q  <= pmode_d;
      pdiv_q   <= pdiv_d;
      pinc_q   <= pinc_d;
      pend_q   <= pend_d;
      acc_q    <= acc_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      wave_q   <= wave_d;
      valid_q  <= valid_d;
      pstart_q <= pstart_d;
    end
  end

  assign wave_out     = wave_q;
  assign valid        = valid_q;
  assign period_start = pstart_q;
  assign cfg_pending  = pend_q;

endmodule

`default_nettype wire

// File: tb/tb_multimode_wave_generator.sv
// ---------------------------------------------------------------------------
// tb_multimode_wave_generator: directed stimulus with a queued reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multimode_wave_generator;

  localparam int W    = 16;
  localparam int DW   = 16;
  localparam int MAXV = 32767;
  localparam int MINV = -32768;

  logic                clk = 1'b0;
  logic                reset, enable, cfg_load;
  logic [1:0]          cfg_mode;
  logic [DW-1:0]       cfg_div;
  logic [W-1:0]        cfg_inc;
  logic signed [W-1:0] wave_out;
  logic                valid, period_start, cfg_pending;

  always #5 clk = ~clk;

  multimode_wave_generator #(
    .WIDTH(W), .DIV_WIDTH(DW), .DEFAULT_INC(256), .DEFAULT_DIV(0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_load(cfg_load),
    .cfg_mode(cfg_mode), .cfg_div(cfg_div), .cfg_inc(cfg_inc),
    .wave_out(wave_out), .valid(valid), .period_start(period_start),
    .cfg_pending(cfg_pending)
  );

  typedef struct {
    logic signed [W-1:0] wave;
    logic                vld;
    logic                ps;
    logic                pend;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0, n_bad = 0, n_step = 0;

  // Reference state, kept in plain integers
  int m_mode, m_div, m_inc, p_mode, p_div, p_inc, m_pend;
  int m_acc, m_dir, m_cnt, m_wave, m_valid, m_ps;

  task automatic model_edge(input logic r, en, ld, input int md, dv, ic);
    int  inc, nacc, ndir;
    bit  wrap, app;
    if (r) begin
      m_mode = 0; m_div = 0; m_inc = 256; p_mode = 0; p_div = 0; p_inc = 0;
      m_pend = 0; m_acc = MINV; m_wave = MINV; m_dir = 0; m_cnt = 0;
      m_valid = 0; m_ps = 0;
      return;
    end
    app = 0; m_valid = 0; m_ps = 0;
    if (en) begin
      if (m_cnt == m_div) begin
        inc  = (m_inc == 0) ? 1 : m_inc;
        nacc = m_acc; ndir = m_dir; wrap = 0;
        case (m_mode)
          0: if (m_dir == 0) begin
               if (m_acc + inc > MAXV) begin nacc = MAXV; ndir = 1; end
               else nacc = m_acc + inc;
             end else begin
               if (m_acc - inc < MINV) begin nacc = MINV; ndir = 0; wrap = 1; end
               else nacc = m_acc - inc;
             end
          1, 2: if (m_acc + inc > MAXV) begin nacc = MINV; wrap = 1; end
                else nacc = m_acc + inc;
          default: if (m_acc - inc < MINV) begin nacc = MAXV; wrap = 1; end
                   else nacc = m_acc - inc;
        endcase
        m_cnt = 0;
        if (wrap && m_pend != 0) app = 1;
        else begin
          m_acc = nacc; m_dir = ndir;
          m_wave = (m_mode == 2) ? ((nacc >= 0) ? MAXV : MINV) : nacc;
          m_valid = 1; m_ps = wrap ? 1 : 0;
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else if (m_pend != 0) begin
      app = 1;
    end
    if (app) begin
      m_mode = p_mode; m_div = p_div; m_inc = p_inc;
      m_acc = (p_mode == 3) ? MAXV : MINV;
      m_wave = m_acc; m_dir = 0; m_cnt = 0;
      m_valid = en ? 1 : 0; m_ps = en ? 1 : 0; m_pend = 0;
    end
    if (ld) begin
      p_mode = md; p_div = dv; p_inc = ic; m_pend = 1;
    end
  endtask

  task automatic step(input logic r, en, ld, input int md, dv, ic);
    exp_t e;
    @(negedge clk);
    reset = r; enable = en; cfg_load = ld;
    cfg_mode = md[1:0]; cfg_div = dv[DW-1:0]; cfg_inc = ic[W-1:0];
    model_edge(r, en, ld, md, dv, ic);
    e.wave = m_wave[W-1:0];
    e.vld  = m_valid[0];
    e.ps   = m_ps[0];
    e.pend = m_pend[0];
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_step++;
    e = sb.pop_front();
    n_cmp++;
    assert (wave_out === e.wave) else begin
      n_bad++; $error("FAIL wave_out step %0d: observed %0d expected %0d", n_step, wave_out, e.wave);
    end
    n_cmp++;
    assert (valid === e.vld) else begin
      n_bad++; $error("FAIL valid step %0d: observed %b expected %b", n_step, valid, e.vld);
    end
    n_cmp++;
    assert (period_start === e.ps) else begin
      n_bad++; $error("FAIL period_start step %0d: observed %b expected %b", n_step, period_start, e.ps);
    end
    n_cmp++;
    assert (cfg_pending === e.pend) else begin
      n_bad++; $error("FAIL cfg_pending step %0d: observed %b expected %b", n_step, cfg_pending, e.pend);
    end
  endtask

  task automatic expect_wave(input string tag, input int v);
    logic signed [W-1:0] ev;
    ev = v[W-1:0];
    n_cmp++;
    assert (wave_out === ev) else begin
      n_bad++; $error("FAIL %s: observed wave_out %0d expected %0d", tag, wave_out, ev);
    end
  endtask

  task automatic expect_bit(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++; $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic run(input logic en, input int n);
    for (int i = 0; i < n; i++) step(1'b0, en, 1'b0, 0, 0, 0);
  endtask

  task automatic load(input logic en, input int md, dv, ic);
    step(1'b0, en, 1'b1, md, dv, ic);
  endtask

  // Steps until the DUT drops cfg_pending, bounded by max cycles.
  task automatic wait_apply(input string tag, input int max);
    for (int i = 0; i < max && cfg_pending !== 1'b0; i++) step(1'b0, 1'b1, 1'b0, 0, 0, 0);
    expect_bit(tag, cfg_pending, 1'b0);
  endtask

  int saw_seq[4]  = '{-16384, 0, 16384, -32768};
  int sq_seq[6]   = '{-32768, 32767, 32767, -32768, -32768, 32767};

  initial begin
    reset = 1'b1; enable = 1'b0; cfg_load = 1'b0;
    cfg_mode = 2'b00; cfg_div = '0; cfg_inc = '0;

    step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    expect_wave("reset_wave", -32768);
    expect_bit("reset_valid", valid, 1'b0);
    expect_bit("reset_pend", cfg_pending, 1'b0);

    // Default triangle: 512 ticks per period
    run(1'b1, 1); expect_wave("tri_tick1", -32512);
    run(1'b1, 1); expect_wave("tri_tick2", -32256);
    run(1'b1, 253); expect_wave("tri_top_minus", 32512);
    run(1'b1, 1); expect_wave("tri_top", 32767);
    run(1'b1, 1); expect_wave("tri_down1", 32511);
    run(1'b1, 255); expect_wave("tri_period_end", -32768);
    expect_bit("tri_period_start", period_start, 1'b1);

    // Divider 3, triangle inc 4096
    load(1'b1, 0, 3, 4096);
    wait_apply("div3_apply", 600);
    expect_wave("div3_start", -32768);
    for (int k = 0; k < 3; k++) begin
      run(1'b1, 1);
      expect_bit("div3_idle_valid", valid, 1'b0);
      expect_wave("div3_hold", -32768);
    end
    run(1'b1, 1);
    expect_bit("div3_tick_valid", valid, 1'b1);
    expect_wave("div3_tick", -28672);
    run(1'b1, 100);

    // Saw-up, inc 16384
    load(1'b1, 1, 0, 16384);
    wait_apply("sawup_apply", 300);
    expect_wave("sawup_start", -32768);
    expect_bit("sawup_start_ps", period_start, 1'b1);
    foreach (saw_seq[k]) begin
      run(1'b1, 1);
      expect_wave("sawup_seq", saw_seq[k]);
    end
    expect_bit("sawup_wrap_ps", period_start, 1'b1);

    // Square, inc 16384
    load(1'b1, 2, 0, 16384);
    wait_apply("square_apply", 10);
    expect_wave("square_start", -32768);
    foreach (sq_seq[k]) begin
      run(1'b1, 1);
      expect_wave("square_seq", sq_seq[k]);
    end

    // Mid-triangle switch to saw-down
    load(1'b1, 0, 0, 256);
    wait_apply("tri_apply", 10);
    run(1'b1, 100);
    load(1'b1, 3, 0, 256);
    run(1'b1, 200);
    expect_bit("sawdn_still_pending", cfg_pending, 1'b1);
    wait_apply("sawdn_apply", 700);
    expect_wave("sawdn_start", 32767);
    expect_bit("sawdn_start_ps", period_start, 1'b1);
    run(1'b1, 1);
    expect_wave("sawdn_next", 32511);

    // Freeze
    run(1'b0, 10);
    expect_wave("freeze_wave", 32511);
    expect_bit("freeze_valid", valid, 1'b0);

    // Frozen apply with inc 0 (treated as 1)
    load(1'b0, 1, 0, 0);
    run(1'b0, 1);
    expect_wave("frozen_apply", -32768);
    expect_bit("frozen_apply_valid", valid, 1'b0);
    run(1'b1, 1); expect_wave("inc0_tick1", -32767);
    run(1'b1, 1); expect_wave("inc0_tick2", -32766);

    // Load coinciding with a frozen apply
    load(1'b0, 2, 5, 100);
    load(1'b0, 3, 0, 512);
    expect_bit("coincide_pend", cfg_pending, 1'b1);
    run(1'b0, 1);
    expect_wave("coincide_sawdn", 32767);
    run(1'b1, 1);
    expect_wave("sawdn512_tick", 32255);

    // Reset mid-ramp aborts a pending config
    run(1'b1, 20);
    load(1'b1, 1, 7, 9);
    step(1'b1, 1'b1, 1'b0, 0, 0, 0);
    expect_wave("midreset_wave", -32768);
    expect_bit("midreset_pend", cfg_pending, 1'b0);
    expect_bit("midreset_valid", valid, 1'b0);
    run(1'b1, 3);
    expect_wave("post_reset_tick3", -32000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multimode_wave_generator.md
MULTIMODE_WAVE_GENERATOR -- requirements
Module: multimode_wave_generator

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample width in bits (signed output), legal range 4..32.
REQ-002 SHALL have parameter DIV_WIDTH, default 16, width of the tick divider.
REQ-003 SHALL have parameter DEFAULT_INC, default 256, increment loaded at reset.
REQ-004 SHALL have parameter DEFAULT_DIV, default 0, divider value loaded at reset.
REQ-005 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port enable  input  1  1 = run; 0 = freeze.
REQ-008 SHALL have port cfg_load  input  1  single-cycle strobe capturing cfg_mode, cfg_div and cfg_inc.
REQ-009 SHALL have port cfg_mode  input  2  wave mode: 00 triangle, 01 saw-up, 10 square, 11 saw-down.
REQ-010 SHALL have port cfg_div  input  DIV_WIDTH  tick divider; a tick occurs every cfg_div+1 enabled cycles.
REQ-011 SHALL have port cfg_inc  input  WIDTH  unsigned step per tick; 0 is treated as 1.
REQ-012 SHALL have port wave_out  output  WIDTH  signed registered sample.
REQ-013 SHALL have port valid  output  1  one-cycle pulse when wave_out updates.
REQ-014 SHALL have port period_start  output  1  one-cycle pulse on the tick that starts a new period.
REQ-015 SHALL have port cfg_pending  output  1  a captured configuration awaits application.

Function
REQ-016 SHALL define MIN = -2^(WIDTH-1) and MAX = 2^(WIDTH-1)-1; all limit compares SHALL use WIDTH+1-bit signed arithmetic so they never overflow.
REQ-017 SHALL keep the following register sets: an active set (mode, div, inc), a pending set, an accumulator acc (WIDTH signed), a direction bit dir (0 = up), and a divider counter.
REQ-018 With enable=1, SHALL tick when counter==active div, clear counter on that tick, and otherwise increment counter.
REQ-019 With enable=0, SHALL hold counter, acc, dir and wave_out, and SHALL force valid=0 and period_start=0.
REQ-020 On each tick SHALL update acc, then on the same edge set wave_out to the new value and pulse valid; tick-to-output latency is one register stage.
REQ-021 In triangle mode, when dir=up: if acc > MAX-inc then acc=MAX and dir=down, else acc+inc.
REQ-022 In triangle mode, when dir=down: if acc < MIN+inc then acc=MIN, dir=up and period_start, else acc-inc.
REQ-023 In saw-up mode: if acc > MAX-inc then acc=MIN and period_start, else acc+inc.
REQ-024 In saw-down mode: if acc < MIN+inc then acc=MAX and period_start, else acc-inc.
REQ-025 Square mode SHALL advance acc as in saw-up and SHALL output wave_out = MAX when the new acc >= 0, and MIN otherwise.
REQ-026 cfg_load SHALL copy the cfg_* inputs into the pending set and set cfg_pending=1; a second cfg_load while pending overwrites the pending set.
REQ-027 With enable=1, the pending set SHALL be applied only on a tick where period_start would fire.
REQ-028 On application, the tick SHALL instead load the active set from pending, set acc and wave_out to the new mode's start value, set dir=up, clear counter, pulse valid and period_start, and clear cfg_pending. The start value is MAX for saw-down and MIN for all other modes.
REQ-029 With enable=0 and cfg_pending=1, SHALL apply the pending set on the next edge as in REQ-028, except that valid and period_start stay 0.
REQ-030 If cfg_load coincides with an application, the application SHALL use the old pending contents, and the new inputs SHALL become pending with cfg_pending remaining 1.

Reset
REQ-031 On reset=1 at a clock edge, SHALL set: active mode=triangle, inc=DEFAULT_INC, div=DEFAULT_DIV; acc=MIN; wave_out=MIN; dir=up; counter=0; valid=0; period_start=0; cfg_pending=0; pending set cleared.
REQ-032 Reset SHALL take priority over enable and cfg_load, and SHALL abort any pending configuration, including mid-period.

Verification (WIDTH=16)
REQ-033 Reset, then enable=1 with defaults: the ticks SHALL produce wave_out -32512, -32256, ..., 32512, 32767, 32511, ..., -32513, -32768. period_start SHALL pulse on -32768, giving a period of 512 ticks, and valid SHALL pulse every cycle.
REQ-034 Load div=3: valid SHALL pulse every 4th cycle, and wave_out SHALL be stable between pulses.
REQ-035 Load saw-up, inc=16384: wave_out SHALL go -32768 (start), -16384, 0, 16384, -32768, with period_start on each -32768.
REQ-036 Load square, inc=16384: wave_out SHALL go -32768, -32768, 32767, 32767, repeating with a period of 4 ticks.
REQ-037 Mid-triangle, load saw-down: cfg_pending SHALL stay 1 until the triangle reaches its MIN tick. That tick SHALL output 32767 with period_start=1 and cfg_pending=0; the next tick SHALL be 32767-inc.
REQ-038 Run with enable=0 for 10 cycles: wave_out SHALL be frozen and valid=0. Then assert reset for one cycle mid-ramp: the next edge SHALL give wave_out=-32768, cfg_pending=0, valid=0.
